// File: rtl/mips.sv
// Single-cycle 32-bit MIPS core with internal instruction/data memories and register file.
// Optional HI/LO multiply/divide unit is enabled by defining MIPS_HILO_EN.

module mips_pc (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d,
    output logic [31:0] OUT
);
    always_ff @(posedge clk) begin
        if (rst) OUT <= '0;
        else     OUT <= d;
    end
endmodule

module mips_imem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   instr
);
    // Contents are preloaded hierarchically by the simulation environment.
    logic [31:0] InstructionMemory [0:WORDS-1];

    assign instr = InstructionMemory[addr];
endmodule

module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] Registers [0:31];

    assign rd1 = (ra1 == 5'd0) ? '0 : Registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : Registers[ra2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) Registers[i] <= '0;
        end else if (we && wa != 5'd0) begin
            Registers[wa] <= wd;
        end
    end
endmodule

module mips #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_o
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] pc, next_pc, pc_plus4, instr;
    logic [31:0] rs_val, rt_val, sext_imm, zext_imm, mem_addr, dm_rdata;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic        rf_we, dm_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] DataMemory [0:DMEM_WORDS-1];

    mips_pc ProgCounter (.clk(clk), .rst(rst), .d(next_pc), .OUT(pc));

    mips_imem #(.WORDS(IMEM_WORDS), .AW(IAW)) IM (.addr(pc[IAW+1:2]), .instr(instr));

    mips_regfile RF (
        .clk(clk), .rst(rst),
        .ra1(rs), .ra2(rt), .rd1(rs_val), .rd2(rt_val),
        .we(rf_we), .wa(rf_wa), .wd(rf_wd)
    );

    assign pc_o     = pc;
    assign pc_plus4 = pc + 32'd4;
    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign sext_imm = {{16{instr[15]}}, instr[15:0]};
    assign zext_imm = {16'd0, instr[15:0]};
    assign mem_addr = rs_val + sext_imm;
    assign dm_rdata = DataMemory[mem_addr[DAW+1:2]];

`ifdef MIPS_HILO_EN
    logic [31:0]        hi, lo, hi_d, lo_d;
    logic               hilo_we;
    logic signed [63:0] sa, sb, prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quo_s, rem_s;

    assign sa     = {{32{rs_val[31]}}, rs_val};
    assign sb     = {{32{rt_val[31]}}, rt_val};
    assign prod_s = sa * sb;
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    assign quo_s  = $signed(rs_val) / $signed(rt_val);
    assign rem_s  = $signed(rs_val) % $signed(rt_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (hilo_we) begin
            hi <= hi_d;
            lo <= lo_d;
        end
    end
`endif

    always_comb begin
        next_pc = pc_plus4;
        rf_we   = 1'b0;
        rf_wa   = rd;
        rf_wd   = '0;
        dm_we   = 1'b0;
`ifdef MIPS_HILO_EN
        hilo_we = 1'b0;
        hi_d    = hi;
        lo_d    = lo;
`endif
        case (opcode)
            6'h00: begin
                rf_we = 1'b1;
                case (funct)
                    6'h20, 6'h21: rf_wd = rs_val + rt_val;
                    6'h22, 6'h23: rf_wd = rs_val - rt_val;
                    6'h24: rf_wd = rs_val & rt_val;
                    6'h25: rf_wd = rs_val | rt_val;
                    6'h26: rf_wd = rs_val ^ rt_val;
                    6'h27: rf_wd = ~(rs_val | rt_val);
                    6'h2A: rf_wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B: rf_wd = {31'd0, rs_val < rt_val};
                    6'h00: rf_wd = rt_val << shamt;
                    6'h02: rf_wd = rt_val >> shamt;
                    6'h03: rf_wd = $signed(rt_val) >>> shamt;
                    6'h08: begin
                        rf_we   = 1'b0;
                        next_pc = rs_val;
                    end
`ifdef MIPS_HILO_EN
                    6'h10: rf_wd = hi;
                    6'h12: rf_wd = lo;
                    6'h18: begin
                        rf_we   = 1'b0;
                        hilo_we = 1'b1;
                        {hi_d, lo_d} = prod_s;
                    end
                    6'h19: begin
                        rf_we   = 1'b0;
                        hilo_we = 1'b1;
                        {hi_d, lo_d} = prod_u;
                    end
                    6'h1A: begin
                        rf_we   = 1'b0;
                        hilo_we = (rt_val != '0);
                        lo_d    = quo_s;
                        hi_d    = rem_s;
                    end
                    6'h1B: begin
                        rf_we   = 1'b0;
                        hilo_we = (rt_val != '0);
                        lo_d    = rs_val / rt_val;
                        hi_d    = rs_val % rt_val;
                    end
`endif
                    default: rf_we = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin rf_we = 1'b1; rf_wa = rt; rf_wd = rs_val + sext_imm; end
            6'h0A: begin rf_we = 1'b1; rf_wa = rt; rf_wd = {31'd0, $signed(rs_val) < $signed(sext_imm)}; end
            6'h0C: begin rf_we = 1'b1; rf_wa = rt; rf_wd = rs_val & zext_imm; end
            6'h0D: begin rf_we = 1'b1; rf_wa = rt; rf_wd = rs_val | zext_imm; end
            6'h0E: begin rf_we = 1'b1; rf_wa = rt; rf_wd = rs_val ^ zext_imm; end
            6'h0F: begin rf_we = 1'b1; rf_wa = rt; rf_wd = {instr[15:0], 16'd0}; end
            6'h23: begin rf_we = 1'b1; rf_wa = rt; rf_wd = dm_rdata; end
            6'h2B: dm_we = 1'b1;
            6'h04: if (rs_val == rt_val) next_pc = pc_plus4 + {sext_imm[29:0], 2'b00};
            6'h05: if (rs_val != rt_val) next_pc = pc_plus4 + {sext_imm[29:0], 2'b00};
            6'h02: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            6'h03: begin
                next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
                rf_we   = 1'b1;
                rf_wa   = 5'd31;
                rf_wd   = pc_plus4;
            end
            default: ;
        endcase
    end

    // Memory survives reset; only the write of the abandoned instruction is blocked.
    always_ff @(posedge clk) begin
        if (!rst && dm_we) DataMemory[mem_addr[DAW+1:2]] <= rt_val;
    end
endmodule

// File: tb/tb_mips.sv
// Directed-vector bench for the single-cycle mips core; HI/LO expectations follow MIPS_HILO_EN.

module tb_mips;
    logic        clk;
    logic        rst;
    logic [31:0] pc_o;
    int          checks;
    int          errors;

    mips #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (.clk(clk), .rst(rst), .pc_o(pc_o));

    always #5 clk = ~clk;

    function automatic logic [31:0] r_op(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] i_op(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_op(int op, int addr);
        return {6'(op), 26'(addr >>> 2)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_im();
        for (int i = 0; i < 256; i++) dut.IM.InstructionMemory[i] = 32'h0;
    endtask

    task automatic load(input int addr, input logic [31:0] w);
        dut.IM.InstructionMemory[addr >>> 2] = w;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        errors = 0;

        clear_im();
        load(32'h00, i_op(8'h08, 0, 8, 5));
        load(32'h04, i_op(8'h08, 0, 9, -3));
        load(32'h08, r_op(8, 9, 10, 0, 8'h20));
        load(32'h0C, r_op(9, 8, 11, 0, 8'h2A));
        load(32'h10, i_op(8'h04, 8, 8, 2));
        load(32'h1C, i_op(8'h05, 8, 8, 5));
        load(32'h20, j_op(8'h03, 32'h40));
        load(32'h40, r_op(31, 0, 0, 0, 8'h08));
        load(32'h24, i_op(8'h08, 0, 0, 7));
        load(32'h28, i_op(8'h2B, 0, 8, 8));
        load(32'h2C, i_op(8'h23, 0, 16, 8));
        load(32'h30, i_op(8'h0F, 0, 13, 32'h1234));
        load(32'h34, i_op(8'h0D, 13, 13, 32'h8000));
        load(32'h38, r_op(0, 9, 14, 1, 8'h03));
        load(32'h3C, j_op(8'h02, 32'h50));
        load(32'h50, r_op(0, 9, 15, 28, 8'h02));
        load(32'h54, r_op(8, 9, 17, 0, 8'h2B));
        load(32'h58, i_op(8'h09, 0, 18, 32'hFFFF));
        load(32'h5C, i_op(8'h0C, 18, 19, 32'h8001));
        load(32'h60, i_op(8'h08, 0, 20, 17));
        load(32'h64, r_op(20, 8, 0, 0, 8'h1A));
        load(32'h68, r_op(0, 0, 21, 0, 8'h12));
        load(32'h6C, r_op(0, 0, 22, 0, 8'h10));
        load(32'h70, r_op(20, 0, 0, 0, 8'h1A));
        load(32'h74, r_op(0, 0, 23, 0, 8'h12));
        load(32'h78, 32'hFC00_0000);
        load(32'h7C, j_op(8'h02, 32'h7C));

        step();
        step();
        check("reset_pc", pc_o, 32'h0);
        for (int r = 0; r < 32; r++) check("reset_reg", dut.RF.Registers[r], 32'h0);
        rst = 1'b0;

        step(); check("pc_after_reset", pc_o, 32'h4);
                check("addi_t0", dut.RF.Registers[8], 32'd5);
        step(); check("addi_neg_t1", dut.RF.Registers[9], 32'hFFFF_FFFD);
        step(); check("add_t2", dut.RF.Registers[10], 32'd2);
        step(); check("slt_t3", dut.RF.Registers[11], 32'd1);
                check("pc_0x10", pc_o, 32'h10);
        step(); check("beq_taken", pc_o, 32'h1C);
        step(); check("bne_not_taken", pc_o, 32'h20);
        step(); check("jal_pc", pc_o, 32'h40);
                check("jal_ra", dut.RF.Registers[31], 32'h24);
        step(); check("jr_pc", pc_o, 32'h24);
        step(); check("zero_reg", dut.RF.Registers[0], 32'h0);
        step(); check("sw_mem", dut.DataMemory[2], 32'd5);
        step(); check("lw_s0", dut.RF.Registers[16], 32'd5);
        step();
        step(); check("lui_ori", dut.RF.Registers[13], 32'h1234_8000);
        step(); check("sra", dut.RF.Registers[14], 32'hFFFF_FFFE);
        step(); check("j_pc", pc_o, 32'h50);
        step(); check("srl", dut.RF.Registers[15], 32'h0000_000F);
        step(); check("sltu", dut.RF.Registers[17], 32'd1);
        step(); check("addiu_sext", dut.RF.Registers[18], 32'hFFFF_FFFF);
        step(); check("andi_zext", dut.RF.Registers[19], 32'h0000_8001);
        step(); check("addi_17", dut.RF.Registers[20], 32'd17);
        step();
`ifdef MIPS_HILO_EN
        check("div_lo", dut.lo, 32'd3);
        check("div_hi", dut.hi, 32'd2);
`endif
        step();
        step();
`ifdef MIPS_HILO_EN
        check("mflo", dut.RF.Registers[21], 32'd3);
        check("mfhi", dut.RF.Registers[22], 32'd2);
`else
        check("mflo_nop", dut.RF.Registers[21], 32'd0);
        check("mfhi_nop", dut.RF.Registers[22], 32'd0);
`endif
        step();
`ifdef MIPS_HILO_EN
        check("div0_lo", dut.lo, 32'd3);
        check("div0_hi", dut.hi, 32'd2);
`endif
        step();
`ifdef MIPS_HILO_EN
        check("mflo_after_div0", dut.RF.Registers[23], 32'd3);
`else
        check("mflo_after_div0", dut.RF.Registers[23], 32'd0);
`endif
        step(); check("undef_op_pc", pc_o, 32'h7C);
                check("undef_op_nowrite", dut.RF.Registers[8], 32'd5);
        step(); check("self_jump", pc_o, 32'h7C);

        // Reset mid-program: the sw at 0x04 must not land
        rst = 1'b1;
        clear_im();
        load(32'h00, i_op(8'h08, 0, 8, 9));
        load(32'h04, i_op(8'h2B, 0, 8, 8));
        step();
        step();
        check("rst2_pc", pc_o, 32'h0);
        check("rst2_t0", dut.RF.Registers[8], 32'h0);
        check("rst2_mem_kept", dut.DataMemory[2], 32'd5);
        rst = 1'b0;
        step(); check("p2_t0", dut.RF.Registers[8], 32'd9);
                check("p2_pc", pc_o, 32'h4);
        rst = 1'b1;
        step(); check("abandon_sw", dut.DataMemory[2], 32'd5);
                check("abandon_pc", pc_o, 32'h0);

        // 17 mod 5 by repeated subtraction
        clear_im();
        load(32'h00, i_op(8'h08, 0, 4, 17));
        load(32'h04, i_op(8'h08, 0, 5, 5));
        load(32'h08, r_op(4, 5, 8, 0, 8'h2A));
        load(32'h0C, i_op(8'h05, 8, 0, 2));
        load(32'h10, r_op(4, 5, 4, 0, 8'h22));
        load(32'h14, j_op(8'h02, 32'h08));
        load(32'h18, r_op(4, 0, 2, 0, 8'h20));
        load(32'h1C, j_op(8'h02, 32'h1C));
        step();
        rst = 1'b0;
        for (int c = 0; c < 40; c++) step();
        check("rem_v0", dut.RF.Registers[2], 32'd2);
        check("rem_pc", pc_o, 32'h1C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
